// File: rtl/touch_pkg.sv
// Shared types for the touch gesture front end:
// FSM state encoding and swipe-direction codes.
package touch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

endpackage

// File: rtl/touch_irq_sync.sv
// Pen-down synchroniser and release debounce counter.
// release_done fires in the last low cycle of a full debounce run.
module touch_irq_sync #(
  parameter int unsigned RELEASE_CNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic active,
  output logic irq_s,
  output logic release_done
);

  localparam int RW = $clog2(RELEASE_CNT + 1);

  logic          sync1;
  logic [RW-1:0] rel_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      irq_s   <= 1'b0;
      rel_cnt <= '0;
    end else begin
      sync1 <= irq;
      irq_s <= sync1;
      if (!active || irq_s)
        rel_cnt <= '0;
      else if (rel_cnt != RW'(RELEASE_CNT))
        rel_cnt <= rel_cnt + RW'(1);
    end
  end

  assign release_done = active && !irq_s &&
                        (rel_cnt == RW'(RELEASE_CNT - 1));

endmodule

// File: rtl/touch_gesture_detector.sv
// Touch press FSM: tap / hold / swipe classification
// plus a wrap-around display-mode counter driven by taps.
module touch_gesture_detector
  import touch_pkg::*;
#(
  parameter int unsigned COORD_W      = 12,
  parameter int unsigned HOLD_CNT     = 24'hffffff,
  parameter int unsigned RELEASE_CNT  = 16,
  parameter int unsigned SWIPE_THRESH = 200,
  parameter int unsigned NUM_MODES    = 4
) (
  input  logic                         iCLK,
  input  logic                         iRST_n,
  input  logic                         iTOUCH_IRQ,
  input  logic [COORD_W-1:0]           iX_COORD,
  input  logic [COORD_W-1:0]           iY_COORD,
  input  logic                         iNEW_COORD,
  output logic                         oTOUCH_ACTIVE,
  output logic                         oTAP,
  output logic                         oHOLD,
  output logic                         oSWIPE,
  output logic [1:0]                   oSWIPE_DIR,
  output logic [COORD_W-1:0]           oX_POS,
  output logic [COORD_W-1:0]           oY_POS,
  output logic [$clog2(NUM_MODES)-1:0] oDISPLAY_MODE
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int PW = $clog2(HOLD_CNT + 1);
  localparam int DW = COORD_W + 1;

  state_t               state, state_nx;
  logic [PW-1:0]        press_cnt;
  logic                 irq_s, release_done;
  logic                 active, coord_we, hold_hit;
  logic [COORD_W-1:0]   x_pos, y_pos, x0, y0;
  logic [COORD_W-1:0]   cur_x, cur_y;
  logic                 start_vld;
  logic signed [DW-1:0] dx, dy;
  logic [DW-1:0]        adx, ady;
  logic                 is_swipe;
  logic [1:0]           dir;
  logic                 tap_nx, swipe_nx;
  logic                 tap_q, swipe_q;
  logic [1:0]           dir_q;
  logic [MW-1:0]        mode_q;

  touch_irq_sync #(
    .RELEASE_CNT(RELEASE_CNT)
  ) u_sync (
    .clk         (iCLK),
    .rst_n       (iRST_n),
    .irq         (iTOUCH_IRQ),
    .active      (active),
    .irq_s       (irq_s),
    .release_done(release_done)
  );

  assign active   = (state != IDLE);
  assign coord_we = iNEW_COORD && active;
  assign hold_hit = (state == PRESS) &&
                    (press_cnt == PW'(HOLD_CNT));

  // A coordinate arriving on the release cycle still counts.
  assign cur_x = coord_we ? iX_COORD : x_pos;
  assign cur_y = coord_we ? iY_COORD : y_pos;

  assign dx  = $signed({1'b0, cur_x}) - $signed({1'b0, x0});
  assign dy  = $signed({1'b0, cur_y}) - $signed({1'b0, y0});
  assign adx = dx[DW-1] ? DW'(-dx) : DW'(dx);
  assign ady = dy[DW-1] ? DW'(-dy) : DW'(dy);

  assign is_swipe = start_vld &&
                    ((adx >= DW'(SWIPE_THRESH)) ||
                     (ady >= DW'(SWIPE_THRESH)));

  always_comb begin
    dir = DIR_RIGHT;
    if (adx >= ady)
      dir = (!dx[DW-1] && dx != '0) ? DIR_RIGHT : DIR_LEFT;
    else
      dir = (!dy[DW-1] && dy != '0) ? DIR_DOWN : DIR_UP;
  end

  always_comb begin
    state_nx = state;
    tap_nx   = 1'b0;
    swipe_nx = 1'b0;
    unique case (state)
      IDLE: if (irq_s) state_nx = PRESS;
      PRESS: begin
        if (hold_hit) begin
          state_nx = release_done ? IDLE : HOLD;
        end else if (release_done) begin
          state_nx = IDLE;
          swipe_nx = is_swipe;
          tap_nx   = !is_swipe;
        end
      end
      HOLD: if (release_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= IDLE;
      press_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!active)
        press_cnt <= irq_s ? PW'(1) : '0;
      else if (press_cnt != PW'(HOLD_CNT))
        press_cnt <= press_cnt + PW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_pos     <= '0;
      y_pos     <= '0;
      x0        <= '0;
      y0        <= '0;
      start_vld <= 1'b0;
    end else begin
      if (coord_we) begin
        x_pos <= iX_COORD;
        y_pos <= iY_COORD;
      end
      if (!active) begin
        start_vld <= 1'b0;
      end else if (coord_we && !start_vld) begin
        x0        <= iX_COORD;
        y0        <= iY_COORD;
        start_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tap_q   <= 1'b0;
      swipe_q <= 1'b0;
      dir_q   <= DIR_RIGHT;
      mode_q  <= '0;
    end else begin
      tap_q   <= tap_nx;
      swipe_q <= swipe_nx;
      if (swipe_nx)
        dir_q <= dir;
      if (tap_nx)
        mode_q <= (mode_q == MW'(NUM_MODES - 1)) ?
                  '0 : mode_q + MW'(1);
    end
  end

  assign oTOUCH_ACTIVE = active;
  assign oTAP          = tap_q;
  assign oHOLD         = hold_hit;
  assign oSWIPE        = swipe_q;
  assign oSWIPE_DIR    = dir_q;
  assign oX_POS        = x_pos;
  assign oY_POS        = y_pos;
  assign oDISPLAY_MODE = mode_q;

endmodule

// File: tb/tb_touch_gesture_detector.sv
// Scoreboard bench for touch_gesture_detector:
// stimulus queues expected events, a monitor pops on each pulse.
module tb_touch_gesture_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq = 1'b0;
  logic        new_coord = 1'b0;
  logic [11:0] x_in = '0;
  logic [11:0] y_in = '0;
  logic        touch_active, tap, hold, swipe;
  logic [1:0]  swipe_dir, mode;
  logic [11:0] x_pos, y_pos;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         kind;
    logic [1:0] dir;
    logic [1:0] mode;
  } ev_t;

  ev_t q[$];

  touch_gesture_detector #(
    .COORD_W     (12),
    .HOLD_CNT    (100),
    .RELEASE_CNT (4),
    .SWIPE_THRESH(200),
    .NUM_MODES   (4)
  ) dut (
    .iCLK         (clk),
    .iRST_n       (rst_n),
    .iTOUCH_IRQ   (irq),
    .iX_COORD     (x_in),
    .iY_COORD     (y_in),
    .iNEW_COORD   (new_coord),
    .oTOUCH_ACTIVE(touch_active),
    .oTAP         (tap),
    .oHOLD        (hold),
    .oSWIPE       (swipe),
    .oSWIPE_DIR   (swipe_dir),
    .oX_POS       (x_pos),
    .oY_POS       (y_pos),
    .oDISPLAY_MODE(mode)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int x, input int y);
    new_coord = 1'b1;
    x_in = x[11:0];
    y_in = y[11:0];
    tick();
    new_coord = 1'b0;
  endtask

  task automatic push(input int kind,
                      input logic [1:0] dir,
                      input logic [1:0] md);
    ev_t e;
    e.kind = kind;
    e.dir  = dir;
    e.mode = md;
    q.push_back(e);
  endtask

  task automatic gesture(input bit use_c,
                         input int x0, input int y0,
                         input int x1, input int y1,
                         input int len,
                         input bit glitch,
                         input bit late);
    int n;
    irq = 1'b1;
    n = 0;
    while (!touch_active && n < 10) begin
      tick();
      n++;
    end
    chk("press_start", touch_active, 1);
    if (use_c) strobe(x0, y0);
    repeat (len / 2) tick();
    if (glitch) begin
      irq = 1'b0;
      repeat (3) tick();
      irq = 1'b1;
    end
    repeat (len / 2) tick();
    if (use_c && !late) strobe(x1, y1);
    irq = 1'b0;
    if (late) begin
      repeat (5) @(posedge clk);
      #1;
      strobe(x1, y1);
    end
    n = 0;
    while (touch_active && n < 30) begin
      tick();
      n++;
    end
    chk("release_end", touch_active, 0);
    repeat (4) tick();
  endtask

  // Monitor: pops one expected event per observed pulse.
  int  run = 0;
  bit  prev_ev = 1'b0;
  int  kind_m;
  ev_t e_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      run     = 0;
      prev_ev = 1'b0;
    end else begin
      run = touch_active ? run + 1 : 0;
      if (tap || hold || swipe) begin
        kind_m = tap ? 0 : (hold ? 1 : 2);
        chk("single_event", int'(tap) + int'(hold) + int'(swipe), 1);
        chk("pulse_width", prev_ev, 0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got kind %0d, required none",
                   kind_m);
        end else begin
          e_m = q.pop_front();
          chk("ev_kind", kind_m, e_m.kind);
          chk("ev_mode", mode, e_m.mode);
          if (kind_m == 2) chk("swipe_dir", swipe_dir, e_m.dir);
          if (kind_m == 1) chk("hold_cycle", run, 100);
          else chk("active_in_event", touch_active, 0);
        end
      end
      prev_ev = tap || hold || swipe;
    end
  end

  initial begin
    repeat (3) tick();
    chk("rst_active", touch_active, 0);
    chk("rst_tap", tap, 0);
    chk("rst_hold", hold, 0);
    chk("rst_swipe", swipe, 0);
    chk("rst_mode", mode, 0);
    chk("rst_xpos", x_pos, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    push(0, 2'b00, 2'd1);
    gesture(1, 500, 500, 520, 510, 20, 0, 0);
    chk("tap_xpos", x_pos, 520);
    chk("tap_ypos", y_pos, 510);

    push(0, 2'b00, 2'd2);
    gesture(0, 0, 0, 0, 0, 10, 0, 0);
    push(0, 2'b00, 2'd3);
    gesture(0, 0, 0, 0, 0, 10, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push(0, 2'b00, 2'(i));
      gesture(0, 0, 0, 0, 0, 10, 0, 0);
    end
    chk("mode_after_wrap", mode, 3);

    push(1, 2'b00, 2'd3);
    gesture(0, 0, 0, 0, 0, 150, 0, 0);
    chk("mode_after_hold", mode, 3);

    push(2, 2'b00, 2'd3);
    gesture(1, 100, 400, 400, 420, 20, 0, 0);
    push(2, 2'b10, 2'd3);
    gesture(1, 400, 100, 380, 350, 20, 0, 0);
    push(2, 2'b00, 2'd3);
    gesture(1, 100, 100, 350, 350, 20, 0, 0);
    push(2, 2'b01, 2'd3);
    gesture(1, 500, 500, 200, 450, 20, 0, 0);
    push(2, 2'b11, 2'd3);
    gesture(1, 500, 500, 510, 250, 20, 0, 0);

    push(0, 2'b00, 2'd0);
    gesture(1, 100, 100, 299, 150, 20, 0, 0);
    push(2, 2'b00, 2'd0);
    gesture(1, 100, 100, 300, 100, 20, 0, 0);
    push(2, 2'b11, 2'd0);
    gesture(1, 300, 300, 300, 100, 20, 0, 0);

    push(0, 2'b00, 2'd1);
    gesture(1, 10, 10, 20, 20, 20, 1, 0);

    push(2, 2'b10, 2'd1);
    gesture(1, 100, 100, 100, 400, 20, 0, 1);
    chk("late_xpos", x_pos, 100);
    chk("late_ypos", y_pos, 400);

    strobe(7, 9);
    repeat (2) tick();
    chk("idle_xpos", x_pos, 100);
    chk("idle_ypos", y_pos, 400);

    push(0, 2'b00, 2'd2);
    gesture(0, 0, 0, 0, 0, 12, 0, 0);

    irq = 1'b1;
    begin
      int n;
      n = 0;
      while (!touch_active && n < 10) begin
        tick();
        n++;
      end
    end
    chk("rst_press_start", touch_active, 1);
    repeat (49) tick();
    rst_n = 1'b0;
    irq = 1'b0;
    #1;
    chk("midrst_active", touch_active, 0);
    chk("midrst_hold", hold, 0);
    chk("midrst_tap", tap, 0);
    chk("midrst_swipe", swipe, 0);
    chk("midrst_mode", mode, 0);
    chk("midrst_xpos", x_pos, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();

    push(0, 2'b00, 2'd1);
    gesture(0, 0, 0, 0, 0, 10, 0, 0);
    chk("final_mode", mode, 1);

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/touch_gesture_detector.md
# touch_gesture_detector

Parametrised touch-panel front end that turns the raw pen-down interrupt and coordinate stream from the touch ADC controller into debounced press state and gesture events. It classifies each press as tap, hold or swipe and keeps a wrap-around display-mode counter advanced by taps. It sits between the touch ADC controller and the LCD display/mode logic.

## Interface
- COORD_W, 12, coordinate width
- HOLD_CNT, 24'hffffff, cycles of continuous press before a hold is declared
- RELEASE_CNT, 16, consecutive cycles of IRQ low that end a press (debounce)
- SWIPE_THRESH, 200, minimum |dx| or |dy| (coordinate units) for a swipe
- NUM_MODES, 4, display-mode count; mode wraps NUM_MODES-1 -> 0
- iCLK  in  1  system clock, 50 MHz
- iRST_n  in  1  reset, asynchronous, active-low
- iTOUCH_IRQ  in  1  pen-down, active-high, asynchronous to iCLK
- iX_COORD  in  COORD_W  X coordinate, valid with iNEW_COORD
- iY_COORD  in  COORD_W  Y coordinate, valid with iNEW_COORD
- iNEW_COORD  in  1  one-cycle strobe, new coordinate pair
- oTOUCH_ACTIVE  out  1  high while FSM is in PRESS or HOLD (including release debounce)
- oTAP  out  1  one-cycle tap pulse
- oHOLD  out  1  one-cycle pulse when hold is reached
- oSWIPE  out  1  one-cycle swipe pulse
- oSWIPE_DIR  out  2  00 right, 01 left, 10 down, 11 up; valid with oSWIPE, held until next swipe
- oX_POS, oY_POS  out  COORD_W each  last coordinate received during the current/last press
- oDISPLAY_MODE  out  clog2(NUM_MODES)  mode index

## Operation
- iTOUCH_IRQ passes a 2-flop synchroniser -> irq_s. All decisions use irq_s.
- FSM states: IDLE, PRESS, HOLD.
- IDLE: press counter and release counter cleared, start-valid flag cleared. irq_s=1 -> PRESS.
- PRESS: press counter increments each cycle, saturating at HOLD_CNT. On reaching HOLD_CNT: oHOLD pulse, -> HOLD.
- First iNEW_COORD in PRESS/HOLD latches start (X0,Y0) and sets start-valid; every iNEW_COORD updates oX_POS/oY_POS. Coordinates outside PRESS/HOLD are ignored.
- Release: release counter increments while irq_s=0 in PRESS/HOLD, clears when irq_s=1. Reaching RELEASE_CNT ends the press -> IDLE.
- Press counter continues during release debounce; a glitch shorter than RELEASE_CNT does not split a press.
- Release from PRESS: dx=X-X0, dy=Y-Y0, signed COORD_W+1 bits. If start-valid and max(|dx|,|dy|) >= SWIPE_THRESH: oSWIPE; direction from larger magnitude axis (tie -> X axis); dx>0 right else left; dy>0 down else up. Otherwise oTAP and oDISPLAY_MODE increments with wrap.
- Release from HOLD: no event.
- Hold reached and release completing on the same cycle: hold wins, no tap/swipe.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0.
- IRQ rise to PRESS: 3 cycles (2 sync + FSM register); oTOUCH_ACTIVE rises the same cycle as PRESS entry.
- oHOLD asserted the cycle the press counter equals HOLD_CNT.
- oTAP/oSWIPE asserted the cycle after release count completes, registered; oDISPLAY_MODE updates in that same cycle; oTOUCH_ACTIVE low in that cycle.
- Event pulses are exactly one cycle; no two events per press.
- iNEW_COORD in the same cycle as release completion is still captured and used for dx/dy.
- Reset mid-press: immediate return to IDLE, no pulse.

## Structure
- Package touch_pkg: state enum (IDLE/PRESS/HOLD), swipe-direction constants (DIR_RIGHT..DIR_UP).
- Sub-module touch_irq_sync: 2-flop synchroniser plus release debounce counter, outputs irq_s and release_done.
- Top: FSM, press counter, coordinate latches, classifier, mode counter.

## Test plan
(Sim params: HOLD_CNT=100, RELEASE_CNT=4, SWIPE_THRESH=200, NUM_MODES=4.)
- IRQ high 20 cycles, coords (500,500)->(520,510), release -> one oTAP, mode 0->1, no swipe.
- Four taps from mode 3 -> mode wraps 3->0 on first, ends at 3; each oTAP 1 cycle.
- IRQ high 150 cycles -> oHOLD at press cycle 100; on release no oTAP, mode unchanged.
- Press with coords (100,400)->(400,420), release -> oSWIPE, DIR=00; (400,100)->(380,350) -> DIR=10; |dx|=|dy|=250 -> X axis.
- During press, IRQ low 3 cycles then high -> press continues, single event at final release.
- iRST_n low mid-press at cycle 50 -> all outputs 0 immediately, no pulse after reset release.
